// File: rtl/dac_stream_out_if.sv
// Sample-frame stream handshake carrying one multi-channel frame per transfer.
interface dac_stream_out_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_stream_out.sv
// Frame FIFO feeding a parallel DAC; a divided sample clock pops one frame per
// period and drives registered data that is stable through the high phase.
module dac_stream_out #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int DIV      = 8
) (
    input  logic                           clk80,
    input  logic                           rst_n,
    dac_stream_out_if.slave                s,
    input  logic                           enable,
    input  logic                           fmt_twos,
    input  logic                           hold_mode,
    input  logic                           underrun_clr,
    output logic                           dac_clk,
    output logic [CHANNELS*DATA_W-1:0]     dac_data,
    output logic                           underrun,
    output logic [$clog2(DEPTH):0]         fill
);
    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int FILL_W  = PTR_W + 1;
    localparam int CNT_W   = $clog2(DIV);

    function automatic logic [FRAME_W-1:0] msb_mask();
        logic [FRAME_W-1:0] m;
        m = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            m[c*DATA_W + DATA_W - 1] = 1'b1;
        end
        return m;
    endfunction

    // Midscale and the two's-complement conversion mask are the same pattern.
    localparam logic [FRAME_W-1:0] MIDSCALE = msb_mask();

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               tick;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign s.s_ready  = rst_n && (fill < FILL_W'(DEPTH));
    assign fifo_empty = (fill == '0);
    assign tick       = enable && (cnt == CNT_W'(DIV - 1));
    assign push       = s.s_valid && s.s_ready;
    assign pop        = tick && !fifo_empty;

    always_comb begin
        cnt_next = '0;
        if (enable && !tick) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk80) begin
        if (push) begin
            mem[wr_ptr] <= s.s_data;
        end
    end

    always_ff @(posedge clk80) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            cnt      <= '0;
            dac_clk  <= 1'b0;
            dac_data <= MIDSCALE;
            underrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fill <= fill + 1'b1;
            end else if (pop && !push) begin
                fill <= fill - 1'b1;
            end

            cnt     <= cnt_next;
            // Registered from the next count so dac_clk tracks the upper half exactly.
            dac_clk <= (cnt_next >= CNT_W'(DIV / 2));

            if (pop) begin
                dac_data <= mem[rd_ptr] ^ (fmt_twos ? MIDSCALE : '0);
            end else if (tick && !hold_mode) begin
                dac_data <= MIDSCALE;
            end

            if (tick && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule
